// File: rtl/stage3_commit_pkg.sv
// Shared types for the stage-3 commit block: FSM state encoding, held result, reset pc default.
package stage3_commit_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RAM_WR = 3'd1,
        OUT_WR = 3'd2,
        COMMIT = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    // Result captured on the accepting handshake; everything downstream reads only this.
    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic        out_wr;
        logic [15:0] pc_next;
        logic        xfr;
        logic        pwr;
    } hold_t;

endpackage

// File: rtl/commit_arch_regs.sv
// Architectural pc / power / fetch-source registers and retired-instruction counter.
module commit_arch_regs
    import stage3_commit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEF,
    parameter int          RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                commit_en,
    input  logic                force_off,
    input  logic [15:0]         pc_next,
    input  logic                pwr_next,
    input  logic                xfr_next,
    output logic [15:0]         pc,
    output logic                is_powered_on,
    output logic                execute_from_ram,
    output logic [RETIRE_W-1:0] retire_count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc               <= RESET_PC;
            is_powered_on    <= 1'b1;
            execute_from_ram <= 1'b0;
            retire_count     <= '0;
        end else if (commit_en) begin
            pc               <= pc_next;
            is_powered_on    <= pwr_next;
            execute_from_ram <= xfr_next;
            retire_count     <= retire_count + 1'b1;
        end else if (force_off) begin
            // Aborted RAM write: power down without retiring the result.
            is_powered_on    <= 1'b0;
        end
    end

endmodule

// File: rtl/stage3_commit.sv
// Stage-3 commit: RAM write, then output write, then architectural update, one result at a time.
// Optional RAM ack timeout enabled by defining STAGE3_COMMIT_RAM_TIMEOUT_EN.
module stage3_commit
    import stage3_commit_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = RESET_PC_DEF,
    parameter int          RETIRE_W    = 32,
    parameter int          RAM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s3_valid,
    output logic                s3_ready,
    input  logic [15:0]         s3_ram_address,
    input  logic [31:0]         s3_ram_in,
    input  logic                s3_ram_is_write,
    input  logic                s3_output_is_write,
    input  logic [15:0]         s3_pc_next,
    input  logic                s3_execute_from_ram_new,
    input  logic                s3_is_powered_on_new,
    output logic                ram_wr_req,
    output logic [15:0]         ram_wr_addr,
    output logic [31:0]         ram_wr_data,
    input  logic                ram_wr_ack,
    output logic                out_wr_en,
    output logic [7:0]          out_wr_addr,
    output logic [31:0]         out_wr_data,
    output logic [15:0]         pc,
    output logic                is_powered_on,
    output logic                execute_from_ram,
    output logic                commit,
    output logic [RETIRE_W-1:0] retire_count,
    output logic                error
);

    state_t state, state_nxt;
    hold_t  hold;
    logic   xfer;
    logic   timeout;

    assign s3_ready = (state == IDLE) && is_powered_on;
    assign xfer     = s3_valid && s3_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                hold.addr    <= s3_ram_address;
                hold.data    <= s3_ram_in;
                hold.out_wr  <= s3_output_is_write;
                hold.pc_next <= s3_pc_next;
                hold.xfr     <= s3_execute_from_ram_new;
                hold.pwr     <= s3_is_powered_on_new;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (s3_ram_is_write)         state_nxt = RAM_WR;
                    else if (s3_output_is_write) state_nxt = OUT_WR;
                    else                         state_nxt = COMMIT;
                end
            end
            RAM_WR: begin
                if (ram_wr_ack)   state_nxt = hold.out_wr ? OUT_WR : COMMIT;
                else if (timeout) state_nxt = HALTED;
            end
            OUT_WR:  state_nxt = COMMIT;
            COMMIT:  state_nxt = hold.pwr ? IDLE : HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decode from state; addr/data come straight from the holding register.
    assign ram_wr_req  = (state == RAM_WR);
    assign ram_wr_addr = hold.addr;
    assign ram_wr_data = hold.data;
    assign out_wr_en   = (state == OUT_WR);
    assign out_wr_addr = hold.addr[7:0];
    assign out_wr_data = hold.data;
    assign commit      = (state == COMMIT);

`ifdef STAGE3_COMMIT_RAM_TIMEOUT_EN
    localparam int TW = (RAM_TIMEOUT < 16) ? 4 : $clog2(RAM_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    // Counts completed RAM_WR cycles; the last allowed cycle without ack aborts.
    assign timeout = (state == RAM_WR) && !ram_wr_ack && (tmo_cnt == TW'(RAM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == RAM_WR) ? tmo_cnt + 1'b1 : '0;
            if (timeout) err_q <= 1'b1;
        end
    end

    assign error = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^RAM_TIMEOUT;
    assign timeout    = 1'b0;
    assign error      = 1'b0;
`endif

    commit_arch_regs #(
        .RESET_PC (RESET_PC),
        .RETIRE_W (RETIRE_W)
    ) u_arch (
        .clk              (clk),
        .reset            (reset),
        .commit_en        (state == COMMIT),
        .force_off        (timeout),
        .pc_next          (hold.pc_next),
        .pwr_next         (hold.pwr),
        .xfr_next         (hold.xfr),
        .pc               (pc),
        .is_powered_on    (is_powered_on),
        .execute_from_ram (execute_from_ram),
        .retire_count     (retire_count)
    );

endmodule

// File: tb/tb_stage3_commit.sv
// Directed bench for stage3_commit: handshake latency, write ordering, halt and reset behaviour.
module tb_stage3_commit;

    logic        clk = 1'b0;
    logic        reset;
    logic        s3_valid;
    logic        s3_ready;
    logic [15:0] s3_ram_address;
    logic [31:0] s3_ram_in;
    logic        s3_ram_is_write;
    logic        s3_output_is_write;
    logic [15:0] s3_pc_next;
    logic        s3_execute_from_ram_new;
    logic        s3_is_powered_on_new;
    logic        ram_wr_req;
    logic [15:0] ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic        ram_wr_ack;
    logic        out_wr_en;
    logic [7:0]  out_wr_addr;
    logic [31:0] out_wr_data;
    logic [15:0] pc;
    logic        is_powered_on;
    logic        execute_from_ram;
    logic        commit;
    logic [31:0] retire_count;
    logic        error;

    int vectors = 0;
    int errs    = 0;

    stage3_commit #(.RESET_PC(16'h0000), .RETIRE_W(32), .RAM_TIMEOUT(15)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .s3_valid                (s3_valid),
        .s3_ready                (s3_ready),
        .s3_ram_address          (s3_ram_address),
        .s3_ram_in               (s3_ram_in),
        .s3_ram_is_write         (s3_ram_is_write),
        .s3_output_is_write      (s3_output_is_write),
        .s3_pc_next              (s3_pc_next),
        .s3_execute_from_ram_new (s3_execute_from_ram_new),
        .s3_is_powered_on_new    (s3_is_powered_on_new),
        .ram_wr_req              (ram_wr_req),
        .ram_wr_addr             (ram_wr_addr),
        .ram_wr_data             (ram_wr_data),
        .ram_wr_ack              (ram_wr_ack),
        .out_wr_en               (out_wr_en),
        .out_wr_addr             (out_wr_addr),
        .out_wr_data             (out_wr_data),
        .pc                      (pc),
        .is_powered_on           (is_powered_on),
        .execute_from_ram        (execute_from_ram),
        .commit                  (commit),
        .retire_count            (retire_count),
        .error                   (error)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic ow, input logic [15:0] a,
                         input logic [31:0] d, input logic [15:0] pcn, input logic pwr, input logic xfr);
        s3_valid                = v;
        s3_ram_is_write         = rw;
        s3_output_is_write      = ow;
        s3_ram_address          = a;
        s3_ram_in               = d;
        s3_pc_next              = pcn;
        s3_is_powered_on_new    = pwr;
        s3_execute_from_ram_new = xfr;
    endtask

    initial begin
        reset      = 1'b1;
        ram_wr_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 16'h0, 1'b1, 1'b0);
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_pc", {16'h0, pc}, 32'h0);
        chk("rst_pwr", {31'h0, is_powered_on}, 32'h1);
        chk("rst_xfr", {31'h0, execute_from_ram}, 32'h0);
        chk("rst_strobes", {29'h0, ram_wr_req, out_wr_en, commit}, 32'h0);
        chk("rst_retire", retire_count, 32'h0);
        chk("rst_error", {31'h0, error}, 32'h0);
        chk("rst_ready", {31'h0, s3_ready}, 32'h1);
        chk("rst_wr_addr", {16'h0, ram_wr_addr}, 32'h0);

        // No side effects: commit at N+1, new pc at N+2
        drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 16'h0004, 1'b1, 1'b1);
        step();
        s3_valid = 1'b0;
        chk("plain_commit", {31'h0, commit}, 32'h1);
        chk("plain_no_wr", {30'h0, ram_wr_req, out_wr_en}, 32'h0);
        chk("plain_ready", {31'h0, s3_ready}, 32'h0);
        chk("plain_pc_old", {16'h0, pc}, 32'h0);
        step();
        chk("plain_pc_new", {16'h0, pc}, 32'h0004);
        chk("plain_xfr", {31'h0, execute_from_ram}, 32'h1);
        chk("plain_retire", retire_count, 32'h1);
        chk("plain_commit_off", {31'h0, commit}, 32'h0);
        chk("plain_ready_back", {31'h0, s3_ready}, 32'h1);

        // RAM write with ack on the third req cycle
        drive(1'b1, 1'b1, 1'b0, 16'h0010, 32'hDEADBEEF, 16'h0008, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 16'hFFFF, 32'h0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("ram_req", {31'h0, ram_wr_req}, 32'h1);
            chk("ram_addr", {16'h0, ram_wr_addr}, 32'h0010);
            chk("ram_data", ram_wr_data, 32'hDEADBEEF);
            chk("ram_ready", {30'h0, s3_ready, commit}, 32'h0);
            if (i == 2) ram_wr_ack = 1'b1;
            step();
        end
        ram_wr_ack = 1'b0;
        chk("ram_req_drop", {31'h0, ram_wr_req}, 32'h0);
        chk("ram_commit", {31'h0, commit}, 32'h1);
        chk("ram_no_out", {31'h0, out_wr_en}, 32'h0);
        step();
        chk("ram_pc", {16'h0, pc}, 32'h0008);
        chk("ram_retire", retire_count, 32'h2);
        chk("ram_xfr", {31'h0, execute_from_ram}, 32'h0);

        // Both writes, ack in first RAM_WR cycle
        drive(1'b1, 1'b1, 1'b1, 16'h0042, 32'h12345678, 16'h000C, 1'b1, 1'b0);
        step();
        s3_valid = 1'b0;
        chk("both_req", {31'h0, ram_wr_req}, 32'h1);
        chk("both_out_early", {31'h0, out_wr_en}, 32'h0);
        ram_wr_ack = 1'b1;
        step();
        ram_wr_ack = 1'b0;
        chk("both_req_drop", {31'h0, ram_wr_req}, 32'h0);
        chk("both_out_en", {31'h0, out_wr_en}, 32'h1);
        chk("both_out_addr", {24'h0, out_wr_addr}, 32'h42);
        chk("both_out_data", out_wr_data, 32'h12345678);
        chk("both_no_commit", {31'h0, commit}, 32'h0);
        step();
        chk("both_out_off", {31'h0, out_wr_en}, 32'h0);
        chk("both_commit", {31'h0, commit}, 32'h1);
        step();
        chk("both_pc", {16'h0, pc}, 32'h000C);
        chk("both_retire", retire_count, 32'h3);

        // Power-off result halts; s3_valid stays high
        drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 16'h0020, 1'b0, 1'b0);
        step();
        chk("halt_commit", {31'h0, commit}, 32'h1);
        step();
        chk("halt_pc", {16'h0, pc}, 32'h0020);
        chk("halt_pwr", {31'h0, is_powered_on}, 32'h0);
        chk("halt_retire", retire_count, 32'h4);
        for (int i = 0; i < 20; i++) begin
            chk("halt_quiet", {28'h0, s3_ready, commit, ram_wr_req, out_wr_en}, 32'h0);
            step();
        end
        chk("halt_retire_hold", retire_count, 32'h4);
        reset = 1'b1;
        s3_valid = 1'b0;
        step();
        reset = 1'b0;
        chk("halt_rst_pc", {16'h0, pc}, 32'h0);
        chk("halt_rst_pwr", {31'h0, is_powered_on}, 32'h1);
        chk("halt_rst_retire", retire_count, 32'h0);
        chk("halt_rst_ready", {31'h0, s3_ready}, 32'h1);

        // Reset during RAM_WR aborts the result
        drive(1'b1, 1'b1, 1'b0, 16'h0055, 32'hCAFEF00D, 16'h0100, 1'b1, 1'b1);
        step();
        s3_valid = 1'b0;
        chk("abort_req", {31'h0, ram_wr_req}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_req_drop", {31'h0, ram_wr_req}, 32'h0);
        chk("abort_pc", {16'h0, pc}, 32'h0);
        chk("abort_retire", retire_count, 32'h0);
        chk("abort_commit", {31'h0, commit}, 32'h0);
        step();
        chk("abort_idle", {30'h0, s3_ready, commit}, 32'h2);
        chk("abort_xfr", {31'h0, execute_from_ram}, 32'h0);

        // RAM write with no ack
        begin
            int req_cycles = 0;
            int commits    = 0;
            drive(1'b1, 1'b1, 1'b1, 16'h0077, 32'h0BADF00D, 16'h0200, 1'b1, 1'b0);
            step();
            s3_valid = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (ram_wr_req) req_cycles++;
                if (commit || out_wr_en) commits++;
                step();
            end
`ifdef STAGE3_COMMIT_RAM_TIMEOUT_EN
            chk("tmo_req_cycles", req_cycles, 32'd15);
            chk("tmo_error", {31'h0, error}, 32'h1);
            chk("tmo_pwr", {31'h0, is_powered_on}, 32'h0);
            chk("tmo_no_commit", commits, 32'd0);
            chk("tmo_pc", {16'h0, pc}, 32'h0);
            chk("tmo_ready", {31'h0, s3_ready}, 32'h0);
`else
            chk("noack_req_cycles", req_cycles, 32'd40);
            chk("noack_error", {31'h0, error}, 32'h0);
            chk("noack_no_commit", commits, 32'd0);
            chk("noack_pwr", {31'h0, is_powered_on}, 32'h1);
`endif
            reset = 1'b1;
            step();
            reset = 1'b0;
            chk("final_error", {31'h0, error}, 32'h0);
            chk("final_req", {31'h0, ram_wr_req}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/stage3_commit.md
Name: stage3_commit

Overview:
- Commit stage directly downstream of the stage-3 execute logic.
- Accepts one resolved instruction result per handshake and performs its side effects in order: RAM write, then output-device write.
- Updates the architectural registers (pc, is_powered_on, execute_from_ram), which feed back to stage 1/3.
- Multi-cycle RAM writes are tolerated through a req/ack handshake; the upstream pipeline is stalled via s3_ready.

Parameters:
RESET_PC, 16'h0000, pc value loaded on reset
RETIRE_W, 32, width of retired-instruction counter
RAM_TIMEOUT, 15, max cycles waiting for ram_wr_ack (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
s3_valid  in  1  stage-3 result valid
s3_ready  out  1  block can accept a result this cycle
s3_ram_address  in  16  RAM write address from stage 3
s3_ram_in  in  32  write data (RAM and output device)
s3_ram_is_write  in  1  result needs a RAM write
s3_output_is_write  in  1  result needs an output-device write
s3_pc_next  in  16  next pc
s3_execute_from_ram_new  in  1  next execute_from_ram
s3_is_powered_on_new  in  1  next power state
ram_wr_req  out  1  RAM write request
ram_wr_addr  out  16  RAM write address
ram_wr_data  out  32  RAM write data
ram_wr_ack  in  1  RAM write done
out_wr_en  out  1  output-device write strobe
out_wr_addr  out  8  output-device address (s3_ram_address[7:0])
out_wr_data  out  32  output-device data
pc  out  16  architectural pc
is_powered_on  out  1  architectural power flag
execute_from_ram  out  1  architectural fetch-source flag
commit  out  1  one-cycle pulse per retired instruction
retire_count  out  RETIRE_W  retired-instruction counter
error  out  1  sticky RAM timeout flag (0 unless the optional feature is compiled in)

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - pc = RESET_PC, is_powered_on = 1, execute_from_ram = 0.
  - ram_wr_req = 0, out_wr_en = 0, commit = 0, retire_count = 0, error = 0.
  - Data/address outputs = 0; state = IDLE.
- Reset mid-operation: aborts any pending RAM request immediately; no commit and no register update for the aborted result.
- All outputs are registered or decoded from state and holding registers only; no combinational path from s3_* inputs to any output.
- s3_ready = 1 only in IDLE with is_powered_on = 1.
- A transfer occurs when s3_valid & s3_ready; all s3_* inputs are captured into holding registers.
- States: IDLE, RAM_WR, OUT_WR, COMMIT, HALTED.
- IDLE: on transfer:
  - ram_is_write -> RAM_WR;
  - else output_is_write -> OUT_WR;
  - else -> COMMIT.
- RAM_WR:
  - ram_wr_req = 1, with ram_wr_addr/ram_wr_data held stable from the holding registers.
  - ram_wr_ack is sampled only while req is high; an ack in the first RAM_WR cycle is legal.
  - On ack: -> OUT_WR if output write is pending, else -> COMMIT. req drops in the next cycle.
- OUT_WR: out_wr_en high for exactly one cycle -> COMMIT.
- Both write flags set: RAM write completes strictly before the out_wr_en pulse.
- COMMIT:
  - commit = 1 for one cycle.
  - At the end of the cycle: pc <= held pc_next, execute_from_ram <= held value, is_powered_on <= held value, retire_count += 1 (wraps modulo 2^RETIRE_W).
  - Next state: HALTED if held is_powered_on_new = 0, else IDLE.
- HALTED: s3_ready = 0; all strobes 0; left only by reset.
- Latency:
  - No side effects: transfer at cycle N, commit at N+1, new pc visible at N+2 (throughput 1 per 2 cycles).
  - RAM write: adds the ack wait of 1 cycle or more.
  - Output write: adds 1 cycle.
- pc wraps naturally (16-bit); no check.

Optional Feature:
- Macro: STAGE3_COMMIT_RAM_TIMEOUT_EN.
- Enabled:
  - A 4-bit+ counter runs in RAM_WR.
  - If no ack after RAM_TIMEOUT cycles: drop req, set error = 1 (sticky until reset), skip the output write and register update, force is_powered_on <= 0, and go to HALTED.
- Disabled: waits for ack indefinitely; error tied to 0.

Decomposition:
- Shared package stage3_commit_pkg: state enum (IDLE, RAM_WR, OUT_WR, COMMIT, HALTED) and RESET_PC default constant.
- One natural sub-module, commit_arch_regs: the pc, power and execute_from_ram registers plus retire counter, with commit-enable.
- The FSM stays in the top module.

Test Plan:
- Reset then s3_valid with no writes, pc_next=16'h0004 -> commit at N+1, pc=16'h0004 at N+2, retire_count=1, no ram_wr_req or out_wr_en.
- RAM write addr=16'h0010, data=32'hDEADBEEF, ack delayed 3 cycles -> req held exactly until ack with stable addr/data, s3_ready=0 throughout, then commit.
- Both writes, addr=16'h0042, data=32'h12345678 -> RAM write first, then one-cycle out_wr_en with out_wr_addr=8'h42 and data 32'h12345678, then commit.
- is_powered_on_new=0 -> after commit: is_powered_on=0, HALTED, s3_ready stays 0 with s3_valid held high for 20 cycles; reset restores pc=RESET_PC and is_powered_on=1.
- Reset asserted during RAM_WR -> req drops next cycle, pc unchanged from RESET_PC, retire_count=0.
- With STAGE3_COMMIT_RAM_TIMEOUT_EN and no ack -> req high for RAM_TIMEOUT cycles, then error=1, is_powered_on=0, no commit pulse.
